// File: rtl/servstolic_qlog.sv
// Change logger for the servstolic q vector: timestamps every change of q into a FIFO
// that firmware drains through a classic Wishbone slave port.
module servstolic_qlog #(
  parameter int NQ    = 16,
  parameter int DEPTH = 16,
  parameter int TSW   = 16
) (
  input  logic          wb_clk,
  input  logic          wb_rst_n,
  input  logic [NQ-1:0] q_i,
  input  logic [3:0]    wb_adr_i,
  input  logic [31:0]   wb_dat_i,
  input  logic          wb_we_i,
  input  logic          wb_cyc_i,
  input  logic          wb_stb_i,
  output logic [31:0]   wb_dat_o,
  output logic          wb_ack_o,
  output logic          irq_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = NQ + TSW;

  localparam logic [1:0] REG_STATUS = 2'd0;
  localparam logic [1:0] REG_CTRL   = 2'd1;
  localparam logic [1:0] REG_HEADQ  = 2'd2;
  localparam logic [1:0] REG_HEADT  = 2'd3;

  logic [NQ-1:0]  q_s;
  logic [NQ-1:0]  q_p;
  logic [TSW-1:0] ts;
  logic [AW:0]    wptr;
  logic [AW:0]    rptr;
  logic [AW:0]    count;
  logic [EW-1:0]  mem [DEPTH];
  logic           en;
  logic           ovf;

  logic           empty;
  logic           full;
  logic           acc;
  logic [1:0]     sel;
  logic           ctrl_wr;
  logic           flush;
  logic           pop;
  logic           evt;
  logic           push;
  logic [EW-1:0]  head;
  logic [7:0]     count8;
  logic [31:0]    rdata;
  logic           unused_bits;

  assign count   = wptr - rptr;
  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign count8  = 8'(count);
  assign irq_o   = ~empty;

  assign sel     = wb_adr_i[3:2];
  assign acc     = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign ctrl_wr = acc & wb_we_i & (sel == REG_CTRL);
  assign flush   = ctrl_wr & wb_dat_i[1];
  assign pop     = acc & ~wb_we_i & (sel == REG_HEADT) & ~empty;

  // A flush discards a coinciding event; a pop in the same cycle makes room in a full FIFO.
  assign evt     = en & (q_s != q_p);
  assign push    = evt & ~flush & (~full | pop);

  assign head    = mem[rptr[AW-1:0]];
  assign unused_bits = ^{wb_adr_i[1:0], wb_dat_i[31:2]};

  always_comb begin
    rdata = '0;
    case (sel)
      REG_STATUS: begin
        rdata[0]    = empty;
        rdata[1]    = full;
        rdata[2]    = ovf;
        rdata[15:8] = count8;
      end
      REG_CTRL:  rdata[0] = en;
      REG_HEADQ: if (!empty) rdata = 32'(head[EW-1:TSW]);
      REG_HEADT: if (!empty) rdata = 32'(head[TSW-1:0]);
      default:   rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk) begin
    if (push) mem[wptr[AW-1:0]] <= {q_s, ts};
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      q_s      <= '0;
      q_p      <= '0;
      ts       <= '0;
      wptr     <= '0;
      rptr     <= '0;
      en       <= 1'b0;
      ovf      <= 1'b0;
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      q_s <= q_i;
      q_p <= q_s;
      ts  <= ts + 1'b1;

      if (push) wptr <= wptr + 1'b1;

      if (flush)    rptr <= wptr;
      else if (pop) rptr <= rptr + 1'b1;

      if (flush)                    ovf <= 1'b0;
      else if (evt && full && !pop) ovf <= 1'b1;

      if (ctrl_wr) en <= wb_dat_i[0];

      // Ack only on the first strobed cycle so every access is a one-cycle pulse.
      if (acc) begin
        wb_ack_o <= 1'b1;
        wb_dat_o <= rdata;
      end else begin
        wb_ack_o <= 1'b0;
        wb_dat_o <= '0;
      end
    end
  end

endmodule

// File: tb/tb_servstolic_qlog.sv
// Scoreboard bench for servstolic_qlog: every q change is predicted with its timestamp
// and compared against what the Wishbone reads return.
module tb_servstolic_qlog;

  localparam int NQ    = 16;
  localparam int DEPTH = 16;
  localparam int TSW   = 8;

  typedef struct packed {
    logic [NQ-1:0]  q;
    logic [TSW-1:0] ts;
  } rec_t;

  logic          wb_clk = 1'b0;
  logic          wb_rst_n;
  logic [NQ-1:0] q_i;
  logic [3:0]    wb_adr_i;
  logic [31:0]   wb_dat_i;
  logic          wb_we_i;
  logic          wb_cyc_i;
  logic          wb_stb_i;
  logic [31:0]   wb_dat_o;
  logic          wb_ack_o;
  logic          irq_o;

  rec_t          sb[$];
  int            cyc_cnt;
  int            checks = 0;
  int            passed = 0;
  bit            en_m;
  logic [NQ-1:0] q_last;

  servstolic_qlog #(.NQ(NQ), .DEPTH(DEPTH), .TSW(TSW)) dut (
    .wb_clk   (wb_clk),
    .wb_rst_n (wb_rst_n),
    .q_i      (q_i),
    .wb_adr_i (wb_adr_i),
    .wb_dat_i (wb_dat_i),
    .wb_we_i  (wb_we_i),
    .wb_cyc_i (wb_cyc_i),
    .wb_stb_i (wb_stb_i),
    .wb_dat_o (wb_dat_o),
    .wb_ack_o (wb_ack_o),
    .irq_o    (irq_o)
  );

  always #5 wb_clk = ~wb_clk;

  // Reference cycle counter: number of clock edges since reset was released.
  always @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) cyc_cnt <= 0;
    else           cyc_cnt <= cyc_cnt + 1;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drive q now; the change reaches q_s at the next edge, so its timestamp is cyc_cnt+1.
  task automatic drive_q(input logic [NQ-1:0] v);
    rec_t r;
    q_i = v;
    if (en_m && v !== q_last) begin
      r.q  = v;
      r.ts = TSW'(cyc_cnt + 1);
      if (sb.size() < DEPTH) sb.push_back(r);
    end
    q_last = v;
  endtask

  task automatic set_q(input logic [NQ-1:0] v);
    @(negedge wb_clk);
    drive_q(v);
  endtask

  task automatic wait_ack(input string name);
    for (int n = 0; n < 8; n++) begin
      @(posedge wb_clk); #1;
      if (wb_ack_o) break;
    end
    if (!wb_ack_o) begin
      checks++;
      $display("[TB] FAIL %s_ack_timeout: ack=%0b required 1", name, wb_ack_o);
    end
  endtask

  task automatic wb_read(input logic [3:0] adr, output logic [31:0] d);
    @(negedge wb_clk);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = adr;
    wait_ack("read");
    d = wb_dat_o;
    @(negedge wb_clk);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
  endtask

  task automatic wb_write(input logic [3:0] adr, input logic [31:0] d);
    @(negedge wb_clk);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = adr; wb_dat_i = d;
    wait_ack("write");
    @(negedge wb_clk);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    wb_rst_n = 1'b0; q_i = '0; wb_adr_i = '0; wb_dat_i = '0;
    wb_we_i = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    sb.delete(); en_m = 1'b0; q_last = '0;
    #12;
    checks++; if (wb_ack_o !== 1'b0) $display("[TB] FAIL reset_ack: got %b required 0", wb_ack_o); else passed++;
    checks++; if (wb_dat_o !== 32'h0) $display("[TB] FAIL reset_dat: got %h required 0", wb_dat_o); else passed++;
    checks++; if (irq_o !== 1'b0) $display("[TB] FAIL reset_irq: got %b required 0", irq_o); else passed++;
    @(negedge wb_clk); wb_rst_n = 1'b1;
    wb_read(4'h0, d);
    checks++; if (d !== 32'h1) $display("[TB] FAIL reset_status: got %h required %h", d, 32'h1); else passed++;
    wb_read(4'h4, d);
    checks++; if (d !== 32'h0) $display("[TB] FAIL reset_ctrl: got %h required %h", d, 32'h0); else passed++;
  endtask

  task automatic test_basic_capture;
    logic [31:0] d;
    rec_t e;
    wb_write(4'h4, 32'h1); en_m = 1'b1;
    set_q(16'h0005);
    @(posedge wb_clk); #1;
    checks++; if (irq_o !== 1'b0) $display("[TB] FAIL capture_early_irq: got %b required 0", irq_o); else passed++;
    @(posedge wb_clk); #1;
    checks++; if (irq_o !== 1'b1) $display("[TB] FAIL capture_irq: got %b required 1", irq_o); else passed++;
    wb_read(4'h0, d);
    checks++; if (d !== 32'h100) $display("[TB] FAIL capture_status: got %h required %h", d, 32'h100); else passed++;
    e = sb.pop_front();
    wb_read(4'h8, d);
    checks++; if (d !== {16'h0, e.q}) $display("[TB] FAIL capture_q: got %h required %h", d, {16'h0, e.q}); else passed++;
    wb_read(4'hC, d);
    checks++; if (d !== {24'h0, e.ts}) $display("[TB] FAIL capture_ts: got %h required %h", d, {24'h0, e.ts}); else passed++;
    wb_read(4'h0, d);
    checks++; if (d !== 32'h1) $display("[TB] FAIL capture_status_after: got %h required %h", d, 32'h1); else passed++;
    checks++; if (irq_o !== 1'b0) $display("[TB] FAIL capture_irq_after: got %b required 0", irq_o); else passed++;
  endtask

  task automatic test_drain;
    logic [31:0] dq, dt, d;
    rec_t e;
    set_q(16'h0001); set_q(16'h0003); set_q(16'h0007);
    repeat (3) @(posedge wb_clk);
    for (int i = 0; i < 3; i++) begin
      e = sb.pop_front();
      wb_read(4'h8, dq);
      wb_read(4'hC, dt);
      checks++; if (dq !== {16'h0, e.q}) $display("[TB] FAIL drain_q%0d: got %h required %h", i, dq, {16'h0, e.q}); else passed++;
      checks++; if (dt !== {24'h0, e.ts}) $display("[TB] FAIL drain_ts%0d: got %h required %h", i, dt, {24'h0, e.ts}); else passed++;
    end
    wb_read(4'h0, d);
    checks++; if (d !== 32'h1) $display("[TB] FAIL drain_status: got %h required %h", d, 32'h1); else passed++;
    checks++; if (irq_o !== 1'b0) $display("[TB] FAIL drain_irq: got %b required 0", irq_o); else passed++;
  endtask

  task automatic test_overflow;
    logic [31:0] d;
    for (int i = 0; i < 20; i++) set_q(16'h0100 + 16'(i));
    repeat (3) @(posedge wb_clk);
    wb_read(4'h0, d);
    checks++; if (d !== 32'h1006) $display("[TB] FAIL ovf_status: got %h required %h", d, 32'h1006); else passed++;
    wb_write(4'h4, 32'h3); sb.delete();
    wb_read(4'h0, d);
    checks++; if (d !== 32'h1) $display("[TB] FAIL ovf_flush_status: got %h required %h", d, 32'h1); else passed++;
    wb_read(4'h4, d);
    checks++; if (d !== 32'h1) $display("[TB] FAIL ovf_ctrl_readback: got %h required %h", d, 32'h1); else passed++;
  endtask

  task automatic test_full_push_pop;
    logic [31:0] d, dq, dt;
    rec_t e, r;
    for (int i = 0; i < DEPTH; i++) set_q(16'h0200 + 16'(i));
    repeat (3) @(posedge wb_clk);
    wb_read(4'h0, d);
    checks++; if (d !== 32'h1002) $display("[TB] FAIL full_status: got %h required %h", d, 32'h1002); else passed++;
    // The change sampled at edge k is pushed at edge k+1, the same edge that acks the pop.
    @(negedge wb_clk);
    q_i = 16'h0300; r.q = 16'h0300; r.ts = TSW'(cyc_cnt + 1); q_last = 16'h0300;
    @(negedge wb_clk);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 4'hC;
    @(posedge wb_clk); #1;
    e = sb.pop_front();
    sb.push_back(r);
    checks++; if (wb_ack_o !== 1'b1) $display("[TB] FAIL pushpop_ack: got %b required 1", wb_ack_o); else passed++;
    checks++; if (wb_dat_o !== {24'h0, e.ts}) $display("[TB] FAIL pushpop_ts: got %h required %h", wb_dat_o, {24'h0, e.ts}); else passed++;
    @(negedge wb_clk);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    wb_read(4'h0, d);
    checks++; if (d !== 32'h1002) $display("[TB] FAIL pushpop_status: got %h required %h", d, 32'h1002); else passed++;
    for (int i = 0; i < DEPTH; i++) begin
      e = sb.pop_front();
      wb_read(4'h8, dq);
      wb_read(4'hC, dt);
      checks++; if (dq !== {16'h0, e.q}) $display("[TB] FAIL full_drain_q%0d: got %h required %h", i, dq, {16'h0, e.q}); else passed++;
      checks++; if (dt !== {24'h0, e.ts}) $display("[TB] FAIL full_drain_ts%0d: got %h required %h", i, dt, {24'h0, e.ts}); else passed++;
    end
    wb_read(4'h0, d);
    checks++; if (d !== 32'h1) $display("[TB] FAIL full_drain_status: got %h required %h", d, 32'h1); else passed++;
  endtask

  task automatic test_disable;
    logic [31:0] d;
    rec_t e;
    set_q(16'h0A0A);
    repeat (3) @(posedge wb_clk);
    wb_write(4'h4, 32'h0); en_m = 1'b0;
    for (int i = 0; i < 6; i++) set_q((i % 2 == 0) ? 16'h5555 : 16'hAAAA);
    repeat (3) @(posedge wb_clk);
    wb_read(4'h0, d);
    checks++; if (d !== 32'h100) $display("[TB] FAIL disable_status: got %h required %h", d, 32'h100); else passed++;
    e = sb.pop_front();
    wb_read(4'h8, d);
    checks++; if (d !== {16'h0, e.q}) $display("[TB] FAIL disable_keep_q: got %h required %h", d, {16'h0, e.q}); else passed++;
    wb_read(4'hC, d);
    checks++; if (d !== {24'h0, e.ts}) $display("[TB] FAIL disable_keep_ts: got %h required %h", d, {24'h0, e.ts}); else passed++;
  endtask

  task automatic test_wrap;
    logic [31:0] d, t1, t2;
    rec_t e;
    wb_write(4'h4, 32'h1); en_m = 1'b1;
    for (int n = 0; n < 300; n++) begin
      @(negedge wb_clk);
      if (((cyc_cnt + 1) & 255) == 250) break;
    end
    drive_q(16'h1111);
    repeat (10) @(negedge wb_clk);
    drive_q(16'h2222);
    repeat (3) @(posedge wb_clk);
    e = sb.pop_front();
    wb_read(4'h8, d);
    checks++; if (d !== {16'h0, e.q}) $display("[TB] FAIL wrap_q0: got %h required %h", d, {16'h0, e.q}); else passed++;
    wb_read(4'hC, t1);
    checks++; if (t1 !== {24'h0, e.ts}) $display("[TB] FAIL wrap_ts0: got %h required %h", t1, {24'h0, e.ts}); else passed++;
    e = sb.pop_front();
    wb_read(4'hC, t2);
    checks++; if (t2 !== {24'h0, e.ts}) $display("[TB] FAIL wrap_ts1: got %h required %h", t2, {24'h0, e.ts}); else passed++;
    checks++; if (!(t2 < t1)) $display("[TB] FAIL wrap_order: got %h after %h required smaller", t2, t1); else passed++;
  endtask

  task automatic test_empty_pop;
    logic [31:0] d;
    rec_t e;
    wb_read(4'hC, d);
    checks++; if (d !== 32'h0) $display("[TB] FAIL empty_pop_data: got %h required 0", d); else passed++;
    @(posedge wb_clk); #1;
    checks++; if (wb_ack_o !== 1'b0) $display("[TB] FAIL empty_pop_ack_drop: got %b required 0", wb_ack_o); else passed++;
    checks++; if (wb_dat_o !== 32'h0) $display("[TB] FAIL empty_pop_dat_idle: got %h required 0", wb_dat_o); else passed++;
    wb_write(4'h0, 32'hFFFF_FFFF);
    wb_read(4'h0, d);
    checks++; if (d !== 32'h1) $display("[TB] FAIL empty_pop_status: got %h required %h", d, 32'h1); else passed++;
    set_q(16'h0BEE);
    repeat (3) @(posedge wb_clk);
    wb_read(4'h0, d);
    checks++; if (d !== 32'h100) $display("[TB] FAIL empty_pop_then_push: got %h required %h", d, 32'h100); else passed++;
    e = sb.pop_front();
    wb_read(4'hC, d);
    checks++; if (d !== {24'h0, e.ts}) $display("[TB] FAIL empty_pop_next_ts: got %h required %h", d, {24'h0, e.ts}); else passed++;
  endtask

  task automatic test_reset_mid;
    logic [31:0] d;
    set_q(16'h0011); set_q(16'h0022); set_q(16'h0033);
    @(negedge wb_clk);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 4'h0;
    @(posedge wb_clk); #1;
    checks++; if (irq_o !== 1'b1) $display("[TB] FAIL midreset_irq_before: got %b required 1", irq_o); else passed++;
    checks++; if (wb_ack_o !== 1'b1) $display("[TB] FAIL midreset_ack_before: got %b required 1", wb_ack_o); else passed++;
    #1 wb_rst_n = 1'b0;
    #1;
    checks++; if (wb_ack_o !== 1'b0) $display("[TB] FAIL midreset_ack: got %b required 0", wb_ack_o); else passed++;
    checks++; if (wb_dat_o !== 32'h0) $display("[TB] FAIL midreset_dat: got %h required 0", wb_dat_o); else passed++;
    checks++; if (irq_o !== 1'b0) $display("[TB] FAIL midreset_irq: got %b required 0", irq_o); else passed++;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; q_i = '0;
    sb.delete(); en_m = 1'b0; q_last = '0;
    @(negedge wb_clk); wb_rst_n = 1'b1;
    wb_read(4'h0, d);
    checks++; if (d !== 32'h1) $display("[TB] FAIL midreset_status: got %h required %h", d, 32'h1); else passed++;
    wb_read(4'h4, d);
    checks++; if (d !== 32'h0) $display("[TB] FAIL midreset_ctrl: got %h required %h", d, 32'h0); else passed++;
  endtask

  initial begin
    test_reset;
    test_basic_capture;
    test_drain;
    test_overflow;
    test_full_push_pop;
    test_disable;
    test_wrap;
    test_empty_pop;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
